// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard: forwarding
// select codes, Tnew/Tuse widths, in-flight writer slot layouts and small helpers.
package hz_pkg;

    localparam int HZ_RA_W = 5;
    localparam int HZ_TN_W = 2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef logic [HZ_TN_W-1:0] tnew_t;
    typedef logic [HZ_RA_W-1:0] reg_t;

    localparam tnew_t TUSE_NONE = {HZ_TN_W{1'b1}};

    typedef struct packed {
        reg_t  a3;
        logic  we;
        tnew_t tnew;
        reg_t  rs;
        reg_t  rt;
    } e_slot_t;

    typedef struct packed {
        reg_t  a3;
        logic  we;
        tnew_t tnew;
        reg_t  rt;
    } m_slot_t;

    typedef struct packed {
        reg_t a3;
        logic we;
    } w_slot_t;

    // Remaining latency one stage later; a ready result stays ready.
    function automatic tnew_t sat_dec(input tnew_t t);
        if (t == tnew_t'(0)) begin
            return tnew_t'(0);
        end else begin
            return t - tnew_t'(1);
        end
    endfunction

    // $0 is hardwired, so it can never be a real producer.
    function automatic logic slot_match(input logic we, input reg_t a3, input reg_t r);
        return we & (a3 == r) & (r != reg_t'(0));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide occupancy counter: loads the op latency when an md op issues
// and counts down; busy while nonzero.
module md_busy_counter
    import hz_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_r;

    // Load on issue, otherwise count down to zero and hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = (cnt_r != {CNT_W{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard unit for the F/D/E/M/W pipeline: tracks in-flight writers in
// E/M/W slots, produces the D-stage stall and all forwarding-mux selects.
module hazard_scoreboard
    import hz_pkg::*;
#(
    parameter int RA_W     = HZ_RA_W,
    parameter int TN_W     = HZ_TN_W,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] d_rs,
    input  logic [RA_W-1:0] d_rt,
    input  logic [TN_W-1:0] d_tuse_rs,
    input  logic [TN_W-1:0] d_tuse_rt,
    input  logic [RA_W-1:0] d_a3,
    input  logic            d_we,
    input  logic [TN_W-1:0] d_tnew,
    input  logic            d_md_start,
    input  logic            d_md_div,
    input  logic            d_md_use,
    output logic            stall,
    output logic [1:0]      fwd_d_rs,
    output logic [1:0]      fwd_d_rt,
    output logic [1:0]      fwd_e_rs,
    output logic [1:0]      fwd_e_rt,
    output logic [0:0]      fwd_m_rt,
    output logic            md_busy
);

    localparam int CNT_W = $clog2(DIV_CYC + 1);

    e_slot_t          e_r;
    m_slot_t          m_r;
    w_slot_t          w_r;
    logic             rs_stall_s;
    logic             rt_stall_s;
    logic             md_stall_s;
    logic             stall_s;
    logic             md_busy_s;
    logic [CNT_W-1:0] md_load_val_s;

    // An operand stalls when some older writer will not be ready by the time it is consumed.
    function automatic logic opnd_stall(input reg_t r, input tnew_t tuse,
                                        input e_slot_t e, input m_slot_t m);
        if (tuse == TUSE_NONE) begin
            return 1'b0;
        end else begin
            return (slot_match(e.we, e.a3, r) & (tuse < e.tnew)) |
                   (slot_match(m.we, m.a3, r) & (tuse < m.tnew));
        end
    endfunction

    function automatic logic [1:0] fwd_d_sel(input reg_t r, input e_slot_t e, input m_slot_t m);
        if (slot_match(e.we, e.a3, r) && (e.tnew == tnew_t'(0))) begin
            return FWD_E;
        end else if (slot_match(m.we, m.a3, r) && (m.tnew == tnew_t'(0))) begin
            return FWD_M;
        end else begin
            return FWD_RF;
        end
    endfunction

    function automatic logic [1:0] fwd_e_sel(input reg_t r, input m_slot_t m, input w_slot_t w);
        if (slot_match(m.we, m.a3, r) && (m.tnew == tnew_t'(0))) begin
            return FWD_M;
        end else if (slot_match(w.we, w.a3, r)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

    // Stall decision: GPR operand hazards plus md unit occupancy.
    always_comb begin
        rs_stall_s = opnd_stall(reg_t'(d_rs), tnew_t'(d_tuse_rs), e_r, m_r);
        rt_stall_s = opnd_stall(reg_t'(d_rt), tnew_t'(d_tuse_rt), e_r, m_r);
        md_stall_s = (d_md_use | d_md_start) & md_busy_s;
        stall_s    = rs_stall_s | rt_stall_s | md_stall_s;
    end

    // Forwarding selects for D, E and the M-stage store data.
    always_comb begin
        fwd_d_rs = fwd_d_sel(reg_t'(d_rs), e_r, m_r);
        fwd_d_rt = fwd_d_sel(reg_t'(d_rt), e_r, m_r);
        fwd_e_rs = fwd_e_sel(e_r.rs, m_r, w_r);
        fwd_e_rt = fwd_e_sel(e_r.rt, m_r, w_r);
        fwd_m_rt = slot_match(w_r.we, w_r.a3, m_r.rt);
    end

    // Writer slots: E takes a bubble on stall; M and W always advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r <= '0;
            m_r <= '0;
            w_r <= '0;
        end else begin
            if (stall_s) begin
                e_r <= '0;
            end else begin
                e_r.a3   <= reg_t'(d_a3);
                e_r.we   <= d_we;
                e_r.tnew <= tnew_t'(d_tnew);
                e_r.rs   <= reg_t'(d_rs);
                e_r.rt   <= reg_t'(d_rt);
            end
            m_r.a3   <= e_r.a3;
            m_r.we   <= e_r.we;
            m_r.tnew <= sat_dec(e_r.tnew);
            m_r.rt   <= e_r.rt;
            w_r.a3   <= m_r.a3;
            w_r.we   <= m_r.we;
        end
    end

    // Latency to load for the md op being issued.
    always_comb begin
        if (d_md_div) begin
            md_load_val_s = CNT_W'(DIV_CYC);
        end else begin
            md_load_val_s = CNT_W'(MULT_CYC);
        end
    end

    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .load     (d_md_start & ~stall_s),
        .load_val (md_load_val_s),
        .busy     (md_busy_s)
    );

    assign stall   = stall_s;
    assign md_busy = md_busy_s;

endmodule
